prog_clk_div_bank: RTL and testbench
====================================

// Module: prog_clk_div_bank
// PURPOSE
//   Synchronous, multi-channel programmable clock divider. Replaces ripple-clocked divide-by-2^k chains.
//   All channels run on the single system clock. Each channel emits a one-cycle tick enable and a
//   near-50% square wave for LEDs and slow logic. Divisors are runtime-programmable, and updates are glitch-free.
// PARAMETERS
//   NUM_CH       4           number of independent divider channels
//   CNT_W        27          divisor/counter width in bits
//   DEFAULT_DIV  50_000_000  divisor loaded into every channel at reset (must be < 2**CNT_W)
// PORTS
//   clk        in   1                  system clock; all logic is rising-edge
//   rst_n      in   1                  asynchronous, active-low reset
//   ch_en      in   NUM_CH             per-channel run enable
//   sync       in   1                  one-cycle pulse: phase-align all channels
//   cfg_valid  in   1                  divisor write request
//   cfg_ready  out  1                  write accepted when cfg_valid && cfg_ready
//   cfg_ch     in   clog2(NUM_CH)      target channel; values >= NUM_CH are accepted and discarded
//   cfg_div    in   CNT_W              new divisor N; 0 is treated as 1
//   tick       out  NUM_CH             registered one-cycle pulse, once per N cycles
//   sq_out     out  NUM_CH             registered square wave: high for ceil(N/2) of every N cycles
// BEHAVIOUR
//   Reset (async assert, sync release):
//     - active_div = max(DEFAULT_DIV,1); cnt = active_div-1; pending = 0; tick = 0; sq_out = 0.
//   Per channel, each edge:
//     - ch_en=0: cnt := active_div-1; tick := 0; sq_out := 0.
//     - ch_en=1, cnt!=0: cnt := cnt-1; tick := 0.
//     - ch_en=1, cnt==0: tick := 1; cnt := div_next-1.
//       div_next = shadow if pending, else active_div; pending clears and active_div := shadow.
//     - sq_out := ch_en & (cnt >= active_div>>1), evaluated on the pre-edge cnt.
//   Latency: with cnt at N-1 and ch_en held high, tick is high after the Nth edge, then every N edges.
//   Config handshake:
//     - cfg_ready = !pending[cfg_ch]; combinational from register state only.
//     - Accept on a running channel: shadow := clamp(cfg_div); pending := 1. Takes effect at the next wrap.
//       The current period always completes with the old divisor; no runt tick or runt high/low phase.
//     - Accept on a disabled channel (ch_en=0 that edge): active_div := clamp(cfg_div) directly;
//       pending stays 0.
//     - Accept on the same edge cnt==0: the current wrap uses the old value; the new value applies at the following wrap.
//   sync=1:
//     - Every channel sets cnt := div_next-1 and applies any pending value.
//     - tick := 0 on that edge. sync overrides a wrap on the same edge.
//   N=1: tick and sq_out are constantly high while enabled.
//   Arithmetic:
//     - Unsigned CNT_W throughout; no carry out of the counter.
//     - active_div>>1 is a floor, so sq_out high time = N - floor(N/2) = ceil(N/2).
//   Mid-operation reset: all state returns to reset values immediately, and pending writes are lost.
//   ch_en deassert mid-period: the channel aborts and restarts from a full period on re-enable.
// STRUCTURE
//   Shared package clk_div_pkg:
//     - CNT_W and DEFAULT_DIV defaults.
//     - Function clamp_div(N) (0 -> 1).
//     - Function clog2-safe sel width (min 1).
//   Sub-module clk_div_channel:
//     - Contents: cnt, active_div, shadow, pending, tick/sq_out regs.
//     - Instantiated NUM_CH times in a generate loop.
//   Top-level contents: cfg_ch decode, cfg_ready mux, sync fan-out.
// TESTING
//   1. DIV=4 default, ch_en[0]=1 from reset release:
//      - tick[0] pulses after edges 4, 8, 12.
//      - sq_out[0] pattern is 1,1,0,0 repeating.
//   2. N=5 on ch1: sq_out high 3 cycles, low 2, with the tick every 5 edges. N=0 and N=1 give tick and sq_out constantly high.
//   3. ch0 running N=8; write N=3 mid-period:
//      - cfg_ready drops, and the current period finishes at 8.
//      - The next period is 3, and cfg_ready rises after that wrap.
//   4. Second write to the same channel while pending: cfg_ready=0, so it is held off.
//      - A concurrent write to another channel is accepted the same cycle.
//   5. Channels with N=6 and N=9 drifting; pulse sync: both ticks occur exactly 6 and 9 edges later. sync on a wrap edge suppresses that tick.
//   6. Assert rst_n=0 asynchronously mid-period with pending set:
//      - Outputs clear before the next edge.
//      - After release, DEFAULT_DIV is active and pending=0.
//   Checks:
//     - Assertion: tick never high two consecutive cycles unless N=1.
//     - Assertion: sq_out period always equals the tick period.

Source files
------------

// File: rtl/clk_div_pkg.sv
// Shared definitions for the programmable clock divider bank.
//   CLK_DIV_CNT_W       default divisor/counter width
//   CLK_DIV_DEFAULT_DIV default divisor loaded into every channel at reset
//   clamp_div()         maps a divisor of 0 to 1 (operates on a 64-bit carrier; callers cast)
//   sel_w()             channel-select width, never narrower than 1 bit
package clk_div_pkg;

  localparam int          CLK_DIV_CNT_W       = 27;
  localparam int unsigned CLK_DIV_DEFAULT_DIV = 50_000_000;

  // A fixed 64-bit carrier lets one function serve any CNT_W up to 64.
  function automatic logic [63:0] clamp_div(input logic [63:0] n);
    return (n == 64'd0) ? 64'd1 : n;
  endfunction

  function automatic int sel_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/clk_div_channel.sv
// One divider channel: down-counter with terminal-count wrap, active/shadow
// divisor pair for glitch-free reprogramming, registered tick and square wave.
//   clk, rst_n  system clock, async active-low reset
//   ch_en       run enable; low holds the channel at the start of a full period
//   sync        phase-align: restart the period and apply any pending divisor
//   cfg_we      accepted divisor write for this channel (already handshaked)
//   cfg_div     new divisor, 0 treated as 1
//   tick        one-cycle pulse at the end of every period
//   sq_out      high for ceil(N/2) of every N cycles
//   pending     shadow divisor waiting for the next wrap or sync
module clk_div_channel
  import clk_div_pkg::*;
#(
  parameter int          CNT_W       = CLK_DIV_CNT_W,
  parameter int unsigned DEFAULT_DIV = CLK_DIV_DEFAULT_DIV
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ch_en,
  input  logic             sync,
  input  logic             cfg_we,
  input  logic [CNT_W-1:0] cfg_div,
  output logic             tick,
  output logic             sq_out,
  output logic             pending
);

  localparam logic [CNT_W-1:0] RST_DIV = CNT_W'(clamp_div(64'(DEFAULT_DIV)));

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] active_q, active_d;
  logic [CNT_W-1:0] shadow_q, shadow_d;
  logic             pending_q, pending_d;
  logic             tick_q, tick_d;
  logic             sq_q, sq_d;

  logic [CNT_W-1:0] div_new;
  logic [CNT_W-1:0] div_next;
  logic             wrap;

  always_comb begin
    div_new  = CNT_W'(clamp_div(64'(cfg_div)));
    wrap     = ch_en && (cnt_q == '0);
    div_next = pending_q ? shadow_q : active_q;

    cnt_d     = cnt_q;
    active_d  = active_q;
    shadow_d  = shadow_q;
    pending_d = pending_q;
    tick_d    = 1'b0;
    sq_d      = 1'b0;

    // A period boundary (natural wrap or forced by sync) is the only point
    // where a pending divisor may take over, so no runt phase is produced.
    if (sync || wrap) begin
      active_d  = div_next;
      pending_d = 1'b0;
    end

    if (!ch_en) begin
      // Disabled channels take new divisors immediately; the counter tracks
      // the divisor that will be live when the channel is re-enabled.
      if (cfg_we) begin
        active_d = div_new;
      end
      cnt_d = active_d - CNT_W'(1);
    end else begin
      sq_d = (cnt_q >= (active_q >> 1));
      if (sync) begin
        cnt_d = div_next - CNT_W'(1);
      end else if (wrap) begin
        tick_d = 1'b1;
        cnt_d  = div_next - CNT_W'(1);
      end else begin
        cnt_d = cnt_q - CNT_W'(1);
      end
      // Written after the boundary logic: a write landing on a wrap edge
      // waits for the following wrap.
      if (cfg_we) begin
        shadow_d  = div_new;
        pending_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= RST_DIV - CNT_W'(1);
      active_q  <= RST_DIV;
      shadow_q  <= RST_DIV;
      pending_q <= 1'b0;
      tick_q    <= 1'b0;
      sq_q      <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      active_q  <= active_d;
      shadow_q  <= shadow_d;
      pending_q <= pending_d;
      tick_q    <= tick_d;
      sq_q      <= sq_d;
    end
  end

  assign tick    = tick_q;
  assign sq_out  = sq_q;
  assign pending = pending_q;

endmodule

// File: rtl/prog_clk_div_bank.sv
// Multi-channel synchronous programmable clock divider.
//   clk, rst_n  system clock, async active-low reset
//   ch_en       per-channel run enable
//   sync        one-cycle pulse phase-aligning every channel
//   cfg_valid/cfg_ready/cfg_ch/cfg_div
//               divisor write handshake; cfg_ch values >= NUM_CH are
//               accepted and dropped
//   tick        per-channel one-cycle pulse every N cycles
//   sq_out      per-channel square wave, high ceil(N/2) of N cycles
module prog_clk_div_bank
  import clk_div_pkg::*;
#(
  parameter int          NUM_CH      = 4,
  parameter int          CNT_W       = CLK_DIV_CNT_W,
  parameter int unsigned DEFAULT_DIV = CLK_DIV_DEFAULT_DIV
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_CH-1:0]           ch_en,
  input  logic                        sync,
  input  logic                        cfg_valid,
  output logic                        cfg_ready,
  input  logic [sel_w(NUM_CH)-1:0]    cfg_ch,
  input  logic [CNT_W-1:0]            cfg_div,
  output logic [NUM_CH-1:0]           tick,
  output logic [NUM_CH-1:0]           sq_out
);

  localparam int SEL_W = sel_w(NUM_CH);

  logic [NUM_CH-1:0] pending_vec;
  logic [NUM_CH-1:0] ch_we;

  // Ready depends only on the selected channel's pending flag, never on
  // cfg_valid; unmapped channel numbers are always ready.
  always_comb begin
    cfg_ready = 1'b1;
    for (int i = 0; i < NUM_CH; i++) begin
      if (cfg_ch == SEL_W'(i)) begin
        cfg_ready = !pending_vec[i];
      end
    end
  end

  always_comb begin
    ch_we = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      ch_we[i] = cfg_valid && cfg_ready && (cfg_ch == SEL_W'(i));
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    clk_div_channel #(
      .CNT_W       (CNT_W),
      .DEFAULT_DIV (DEFAULT_DIV)
    ) u_ch (
      .clk     (clk),
      .rst_n   (rst_n),
      .ch_en   (ch_en[g]),
      .sync    (sync),
      .cfg_we  (ch_we[g]),
      .cfg_div (cfg_div),
      .tick    (tick[g]),
      .sq_out  (sq_out[g]),
      .pending (pending_vec[g])
    );
  end

endmodule

// File: tb/tb_prog_clk_div_bank.sv
module tb_prog_clk_div_bank;

  localparam int NUM_CH = 4;
  localparam int CNT_W  = 27;
  localparam int DEF    = 4;

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic [NUM_CH-1:0] ch_en = '0;
  logic              sync = 1'b0;
  logic              cfg_valid = 1'b0;
  logic              cfg_ready;
  logic [1:0]        cfg_ch = '0;
  logic [CNT_W-1:0]  cfg_div = '0;
  logic [NUM_CH-1:0] tick;
  logic [NUM_CH-1:0] sq_out;

  prog_clk_div_bank #(
    .NUM_CH      (NUM_CH),
    .CNT_W       (CNT_W),
    .DEFAULT_DIV (DEF)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ch_en     (ch_en),
    .sync      (sync),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_ch    (cfg_ch),
    .cfg_div   (cfg_div),
    .tick      (tick),
    .sq_out    (sq_out)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [NUM_CH-1:0] tick;
    logic [NUM_CH-1:0] sq;
    logic [NUM_CH-1:0] p1;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_cmp = 0;
  int   n_err = 0;
  logic [NUM_CH-1:0] prev_tick = '0;

  // Reference model: each channel is a period length and a position inside
  // the current period, plus an optional queued period length.
  int per [NUM_CH];
  int pos [NUM_CH];
  int shd [NUM_CH];
  bit pend[NUM_CH];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < NUM_CH; c++) begin
      per[c]  = DEF;
      pos[c]  = 0;
      shd[c]  = DEF;
      pend[c] = 1'b0;
    end
  endtask

  // Called just after a falling edge: drives one cycle of inputs, checks
  // cfg_ready, predicts the outputs after the next rising edge.
  task automatic step(input logic [NUM_CH-1:0] en, input bit s, input bit v,
                      input logic [1:0] ch, input int d);
    exp_t e;
    int   nv;
    ch_en     = en;
    sync      = s;
    cfg_valid = v;
    cfg_ch    = ch;
    cfg_div   = CNT_W'(d);
    #1;
    chk("cfg_ready", {31'd0, cfg_ready}, {31'd0, !pend[ch]});
    nv = (d == 0) ? 1 : d;
    e  = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      bit we;
      we = v && (int'(ch) == c) && !pend[c];
      e.p1[c] = (per[c] == 1);
      if (!en[c]) begin
        if (s && pend[c]) begin
          per[c]  = shd[c];
          pend[c] = 1'b0;
        end
        if (we) per[c] = nv;
        pos[c] = 0;
      end else begin
        e.sq[c] = (pos[c] < (per[c] + 1) / 2);
        if (s || pos[c] == per[c] - 1) begin
          e.tick[c] = !s;
          if (pend[c]) begin
            per[c]  = shd[c];
            pend[c] = 1'b0;
          end
          pos[c] = 0;
        end else begin
          pos[c]++;
        end
        if (we) begin
          shd[c]  = nv;
          pend[c] = 1'b1;
        end
      end
    end
    exp_q.push_back(e);
    @(negedge clk);
  endtask

  task automatic run(input logic [NUM_CH-1:0] en, input int n);
    for (int i = 0; i < n; i++) step(en, 1'b0, 1'b0, 2'd0, 0);
  endtask

  task automatic mid_reset();
    #2 rst_n = 1'b0;
    #1;
    chk("rst_tick", {28'd0, tick}, 32'd0);
    chk("rst_sq", {28'd0, sq_out}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  // Monitor: compares registered outputs against the queued prediction.
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      chk("tick", {28'd0, tick}, {28'd0, mon_e.tick});
      chk("sq_out", {28'd0, sq_out}, {28'd0, mon_e.sq});
      for (int c = 0; c < NUM_CH; c++) begin
        if (tick[c] && prev_tick[c]) chk("b2b_tick_period1", {31'd0, mon_e.p1[c]}, 32'd1);
      end
      prev_tick = tick;
    end else begin
      prev_tick = '0;
    end
  end

  logic [NUM_CH-1:0] r_en;

  initial begin
    model_reset();
    #1 rst_n = 1'b0;
    #1;
    chk("init_tick", {28'd0, tick}, 32'd0);
    chk("init_sq", {28'd0, sq_out}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Default divisor 4 on channel 0.
    run(4'b0001, 12);

    // Program disabled channels: 5, 0 (as 1) and 1, then run them all.
    step(4'b0001, 1'b0, 1'b1, 2'd1, 5);
    step(4'b0001, 1'b0, 1'b1, 2'd2, 0);
    step(4'b0001, 1'b0, 1'b1, 2'd3, 1);
    run(4'b1111, 15);

    // Running channel 0: switch to 8, then to 3 mid-period.
    step(4'b1111, 1'b0, 1'b1, 2'd0, 8);
    run(4'b1111, 12);
    step(4'b1111, 1'b0, 1'b1, 2'd0, 3);
    // Held-off second write, then another channel accepted meanwhile.
    step(4'b1111, 1'b0, 1'b1, 2'd0, 7);
    step(4'b1111, 1'b0, 1'b1, 2'd1, 6);
    run(4'b1111, 14);

    // Channels at 6 and 9, drift, then sync.
    step(4'b1111, 1'b0, 1'b1, 2'd2, 6);
    step(4'b1111, 1'b0, 1'b1, 2'd3, 9);
    run(4'b1111, 23);
    step(4'b1111, 1'b1, 1'b0, 2'd0, 0);
    run(4'b1111, 20);
    for (int i = 0; i < 20 && pos[2] != per[2] - 1; i++) run(4'b1111, 1);
    step(4'b1111, 1'b1, 1'b0, 2'd0, 0);
    run(4'b1111, 12);

    // Reset while a write is pending on channel 1.
    for (int i = 0; i < 20 && pend[1]; i++) run(4'b1111, 1);
    step(4'b1111, 1'b0, 1'b1, 2'd1, 11);
    run(4'b1111, 2);
    mid_reset();
    run(4'b0011, 10);

    // Random traffic.
    r_en = 4'b1111;
    for (int i = 0; i < 3000; i++) begin
      for (int c = 0; c < NUM_CH; c++) begin
        if ($urandom_range(31) == 0) r_en[c] = ~r_en[c];
      end
      step(r_en, ($urandom_range(49) == 0), ($urandom_range(3) == 0),
           2'($urandom_range(3)), int'($urandom_range(12)));
      if ($urandom_range(999) == 0) mid_reset();
    end

    run(4'b0000, 2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
